// File: rtl/audio_pkg.sv
// Shared audio datapath definitions: sample/Q15 widths, allpass FSM states,
// and the 18-to-16-bit saturation used by the comb stage, mixer and diffuser.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int Q15_FRAC = 15;
  localparam logic signed [15:0] Q15_HALF = 16'sd16384;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    READ,
    CALC,
    WRITE
  } ap_state_t;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Single-port delay-line storage with synchronous read-first output.
// The array has no reset so it maps onto block RAM.
module delay_ram
  import audio_pkg::*;
#(
  parameter int DEPTH = 556,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [AW-1:0]              addr,
  input  logic signed [SAMPLE_W-1:0] wdata,
  output logic signed [SAMPLE_W-1:0] rdata
);

  logic signed [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/allpass_diffuser.sv
// Schroeder allpass diffuser: one sample per four cycles through a
// CLEAR/IDLE/READ/CALC/WRITE sequence around a single-port delay RAM.
module allpass_diffuser
  import audio_pkg::*;
#(
  parameter int DELAY = 556,
  parameter logic signed [15:0] GAIN = Q15_HALF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] din,
  output logic               out_valid,
  output logic signed [15:0] dout,
  output logic               overrun
);

  localparam int AW = $clog2(DELAY);
  localparam logic [AW-1:0] LAST = AW'(DELAY - 1);

  ap_state_t state, next_state;
  logic [AW-1:0] ptr, clr_cnt;
  logic signed [SAMPLE_W-1:0] x_reg, w_reg, y_reg;

  logic                       ram_we;
  logic [AW-1:0]              ram_addr;
  logic signed [SAMPLE_W-1:0] ram_wdata, ram_rdata;

  logic signed [31:0]         p1, p2;
  logic signed [17:0]         p1_sh, p2_sh, w_sum, y_sum;
  logic signed [SAMPLE_W-1:0] w_calc, y_calc;

  delay_ram #(.DEPTH(DELAY), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= CLEAR;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = ptr;
    ram_wdata  = w_reg;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
        if (clr_cnt == LAST)
          next_state = IDLE;
      end
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          next_state = READ;
      end
      READ:  next_state = CALC;
      CALC:  next_state = WRITE;
      WRITE: begin
        ram_we     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = CLEAR;
    endcase
  end

  // d arrives from the RAM during CALC; w feeds the second product directly
  assign p1     = 32'(GAIN) * 32'(ram_rdata);
  assign p1_sh  = 18'(p1 >>> Q15_FRAC);
  assign w_sum  = 18'(x_reg) + p1_sh;
  assign w_calc = sat16(w_sum);
  assign p2     = 32'(GAIN) * 32'(w_calc);
  assign p2_sh  = 18'(p2 >>> Q15_FRAC);
  assign y_sum  = 18'(ram_rdata) - p2_sh;
  assign y_calc = sat16(y_sum);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt   <= '0;
      ptr       <= '0;
      x_reg     <= '0;
      w_reg     <= '0;
      y_reg     <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == CLEAR)
        clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
      if (in_valid && in_ready)
        x_reg <= din;
      if (in_valid && !in_ready)
        overrun <= 1'b1;
      if (state == CALC) begin
        w_reg <= w_calc;
        y_reg <= y_calc;
      end
      if (state == WRITE) begin
        dout      <= y_reg;
        out_valid <= 1'b1;
        ptr       <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
    end
  end

endmodule
